change_dispenser: RTL and testbench

//  - Downstream stage of the vending FSM. Consumes the one-cycle soda/vend pulse and the 3-bit change

---
 rtl/vm_pkg.sv | 28 ++
 rtl/hopper_handshake.sv | 97 +++++++++
 rtl/change_dispenser.sv | 104 ++++++++++
 tb/tb_change_dispenser.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: types and constants shared by the vending-machine change path.
//   disp_state_t : dispenser/handshake state encoding
//   coin_t       : coin selected for the current hopper handshake
//   NICKEL_UNITS, DIME_UNITS : coin values in 5c units
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        REQ,
        REL,
        DONE,
        FAULT
    } disp_state_t;

    typedef enum logic {
        NICKEL,
        DIME
    } coin_t;

    localparam int unsigned NICKEL_UNITS = 1;
    localparam int unsigned DIME_UNITS   = 2;

    function automatic int unsigned coin_units(input coin_t c);
        return (c == DIME) ? DIME_UNITS : NICKEL_UNITS;
    endfunction

endpackage

// File: rtl/hopper_handshake.sv
// hopper_handshake: one req/ack exchange with the coin hopper per start pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a handshake for `coin` (accepted only when idle)
//   coin        : coin to eject, latched on start
//   ack         : hopper acknowledge level (high = coin ejected)
//   req_d/req_n : registered dime/nickel request, at most one high
//   coin_done   : one-cycle strobe when the hopper has returned to ready
//   timeout     : sticky, hopper failed to respond (DISPENSE_TIMEOUT_EN only)
// Macro DISPENSE_TIMEOUT_EN enables the per-phase watchdog counter.
module hopper_handshake
    import vm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  coin_t coin,
    input  logic  ack,
    output logic  req_d,
    output logic  req_n,
    output logic  coin_done,
    output logic  timeout
);

    if (TIMEOUT_CYC < 2) begin : g_cfg_check
        $error("hopper_handshake: TIMEOUT_CYC must be at least 2");
    end

    disp_state_t phase, phase_next;
    coin_t       coin_q;
    logic        expired;

    always_comb begin
        phase_next = phase;
        coin_done  = 1'b0;
        case (phase)
            IDLE: if (start) phase_next = REQ;
            REQ: begin
                if (ack) phase_next = REL;
                else if (expired) phase_next = FAULT;
            end
            // Completion is reported only once ack has fallen, so a
            // lingering ack can never be taken for the next coin.
            REL: begin
                if (!ack) begin
                    phase_next = IDLE;
                    coin_done  = 1'b1;
                end else if (expired) begin
                    phase_next = FAULT;
                end
            end
            FAULT:   phase_next = FAULT;
            default: phase_next = IDLE;
        endcase
    end

    // Requests are registered from the phase actually held across the
    // edge: they rise one cycle after entering REQ and fall on the edge
    // that sees ack or the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= IDLE;
            coin_q <= NICKEL;
            req_d  <= 1'b0;
            req_n  <= 1'b0;
        end else begin
            phase <= phase_next;
            if (phase == IDLE && start) coin_q <= coin;
            req_d <= (phase == REQ) && (phase_next == REQ) && (coin_q == DIME);
            req_n <= (phase == REQ) && (phase_next == REQ) && (coin_q == NICKEL);
        end
    end

    assign timeout = (phase == FAULT);

`ifdef DISPENSE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (phase_next != phase) begin
            cnt <= '0;
        end else if (phase == REQ || phase == REL) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (phase == REQ || phase == REL) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign expired = 1'b0;
`endif

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out vending change through a coin hopper.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_soda         : vend pulse, qualifies i_change (ignored unless idle)
//   i_change       : change owed in 5c units
//   i_hop_ack      : hopper acknowledge level
//   o_dime_req     : hopper request, one dime
//   o_nickel_req   : hopper request, one nickel
//   o_busy         : payout in progress
//   o_done         : one-cycle pulse at payout completion
//   o_fault        : sticky hopper timeout (constant 0 unless DISPENSE_TIMEOUT_EN)
// Macro DISPENSE_TIMEOUT_EN enables the hopper watchdog and the FAULT state.
// All outputs are registers; status outputs follow the state one cycle later.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned CHG_W       = 3,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_soda,
    input  logic [CHG_W-1:0] i_change,
    input  logic             i_hop_ack,
    output logic             o_dime_req,
    output logic             o_nickel_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault
);

    disp_state_t      state, state_next;
    logic [CHG_W-1:0] remaining;
    coin_t            coin_pick, coin_sel;
    logic             start, coin_done, timeout;

    // Dimes while at least 10c is owed; a lone nickel finishes an odd balance.
    always_comb begin
        coin_pick = (32'(remaining) >= DIME_UNITS) ? DIME : NICKEL;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (i_soda) state_next = (i_change == '0) ? DONE : SEL;
            end
            SEL: begin
                if (remaining == '0) begin
                    state_next = DONE;
                end else begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            // REQ covers the whole hopper exchange (REQ and REL phases
            // live in the handshake block).
            REQ: begin
                if (timeout) state_next = FAULT;
                else if (coin_done) state_next = SEL;
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            coin_sel  <= NICKEL;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_fault   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && i_soda) begin
                remaining <= i_change;
            end else if (coin_done) begin
                remaining <= remaining - CHG_W'(coin_units(coin_sel));
            end
            if (start) coin_sel <= coin_pick;
            o_busy  <= (state != IDLE) && (state != FAULT);
            o_done  <= (state == DONE);
            o_fault <= (state == FAULT);
        end
    end

    hopper_handshake #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_hs (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (start),
        .coin     (coin_pick),
        .ack      (i_hop_ack),
        .req_d    (o_dime_req),
        .req_n    (o_nickel_req),
        .coin_done(coin_done),
        .timeout  (timeout)
    );

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
module tb_change_dispenser;

    localparam int unsigned CHG_W = 3;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             soda    = 1'b0;
    logic [CHG_W-1:0] change  = '0;
    logic             hop_ack = 1'b0;
    logic             dime_req, nickel_req, busy, done, fault;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // hopper model controls
    logic        hop_en    = 1'b0;
    int unsigned ack_delay = 3;
    int unsigned ack_hold  = 1;

    // hopper / monitor statistics
    int unsigned dimes       = 0;
    int unsigned nickels     = 0;
    int unsigned dimes_at_n  = 0;
    int unsigned hcnt        = 0;
    int unsigned req_rises   = 0;
    int unsigned stale_req   = 0;
    int unsigned both_high   = 0;
    logic        prev_req    = 1'b0;

    always #5 clk = ~clk;

    change_dispenser #(
        .CHG_W      (CHG_W),
        .TIMEOUT_CYC(8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_soda      (soda),
        .i_change    (change),
        .i_hop_ack   (hop_ack),
        .o_dime_req  (dime_req),
        .o_nickel_req(nickel_req),
        .o_busy      (busy),
        .o_done      (done),
        .o_fault     (fault)
    );

    // Hopper: raises ack ack_delay cycles after a req appears (counting the
    // coin), then drops it ack_hold cycles after the req has gone away.
    always @(posedge clk) begin
        #1;
        if (!hop_en || !rst_n) begin
            hop_ack = 1'b0;
            hcnt    = 0;
        end else if (!hop_ack) begin
            if (dime_req || nickel_req) begin
                hcnt++;
                if (hcnt >= ack_delay) begin
                    hop_ack = 1'b1;
                    hcnt    = 0;
                    if (dime_req) begin
                        dimes++;
                    end else begin
                        nickels++;
                        dimes_at_n = dimes;
                    end
                end
            end else begin
                hcnt = 0;
            end
        end else if (!dime_req && !nickel_req) begin
            hcnt++;
            if (hcnt >= ack_hold) begin
                hop_ack = 1'b0;
                hcnt    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (dime_req && nickel_req) both_high <= both_high + 1;
        if ((dime_req || nickel_req) && !prev_req) begin
            req_rises <= req_rises + 1;
            if (hop_ack) stale_req <= stale_req + 1;
        end
        prev_req <= dime_req || nickel_req;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_num(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic vend(input logic [CHG_W-1:0] c);
        soda   = 1'b1;
        change = c;
        tick();
        soda   = 1'b0;
        change = '0;
    endtask

    task automatic run(input int unsigned n, output int unsigned done_cnt);
        done_cnt = 0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            if (done) done_cnt++;
        end
    endtask

    initial begin
        int unsigned d0, n0, r0, s0, dc, waits;

        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) tick();
        chk_bit("rst_dime_req", dime_req, 1'b0);
        chk_bit("rst_nickel_req", nickel_req, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_fault", fault, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        chk_bit("idle_busy", busy, 1'b0);
        chk_bit("idle_done", done, 1'b0);

        // ---- zero change: done one cycle after the sample edge ----
        r0 = req_rises;
        vend(3'd0);
        chk_bit("zero_done_n", done, 1'b0);
        tick();
        chk_bit("zero_done_n1", done, 1'b1);
        chk_bit("zero_busy_n1", busy, 1'b1);
        tick();
        chk_bit("zero_done_off", done, 1'b0);
        chk_bit("zero_busy_off", busy, 1'b0);
        chk_num("zero_no_req", req_rises - r0, 0);

        // ---- change 7: three dimes then one nickel ----
        hop_en    = 1'b1;
        ack_delay = 3;
        ack_hold  = 1;
        d0 = dimes;
        n0 = nickels;
        vend(3'd7);
        chk_bit("c7_req_n", dime_req, 1'b0);
        tick();
        chk_bit("c7_req_n1", dime_req, 1'b0);
        tick();
        chk_bit("c7_req_n2", dime_req, 1'b1);
        chk_bit("c7_busy", busy, 1'b1);
        run(120, dc);
        chk_num("c7_done_cycles", dc, 1);
        chk_num("c7_dimes", dimes - d0, 3);
        chk_num("c7_nickels", nickels - n0, 1);
        chk_num("c7_nickel_last", dimes_at_n - d0, 3);
        chk_bit("c7_busy_end", busy, 1'b0);

        // ---- change 1 with an ignored second vend ----
        d0 = dimes;
        n0 = nickels;
        vend(3'd1);
        tick();
        tick();
        chk_bit("c1_nickel_req", nickel_req, 1'b1);
        chk_bit("c1_dime_req", dime_req, 1'b0);
        vend(3'd4);
        run(60, dc);
        chk_num("c1_done_cycles", dc, 1);
        chk_num("c1_nickels", nickels - n0, 1);
        chk_num("c1_dimes", dimes - d0, 0);
        chk_bit("c1_busy_end", busy, 1'b0);

        // ---- ack held high across release ----
        ack_hold = 10;
        s0 = stale_req;
        d0 = dimes;
        n0 = nickels;
        vend(3'd4);
        run(80, dc);
        chk_num("hold_done_cycles", dc, 1);
        chk_num("hold_dimes", dimes - d0, 2);
        chk_num("hold_nickels", nickels - n0, 0);
        chk_num("hold_stale_req", stale_req - s0, 0);
        ack_hold = 1;

        // ---- hopper never acknowledges ----
        hop_en = 1'b0;
        r0 = req_rises;
        vend(3'd3);
`ifdef DISPENSE_TIMEOUT_EN
        for (int k = 0; k < 30 && !fault; k++) tick();
        chk_bit("to_fault", fault, 1'b1);
        chk_bit("to_dime_low", dime_req, 1'b0);
        chk_bit("to_nickel_low", nickel_req, 1'b0);
        chk_bit("to_busy_low", busy, 1'b0);
        repeat (10) tick();
        vend(3'd2);
        repeat (5) tick();
        chk_bit("to_fault_sticky", fault, 1'b1);
        chk_bit("to_dime_still_low", dime_req, 1'b0);
`else
        repeat (40) tick();
        chk_bit("nto_fault", fault, 1'b0);
        chk_bit("nto_busy", busy, 1'b1);
        chk_bit("nto_dime_waiting", dime_req, 1'b1);
`endif
        chk_num("noack_one_req", req_rises - r0, 1);
        rst_n = 1'b0;
        tick();
        chk_bit("noack_rst_fault", fault, 1'b0);
        chk_bit("noack_rst_busy", busy, 1'b0);
        chk_bit("noack_rst_dime", dime_req, 1'b0);
        rst_n = 1'b1;
        tick();
        hop_en = 1'b1;
        tick();

        // ---- reset during the second dime of change 5 ----
        d0 = dimes;
        n0 = nickels;
        r0 = req_rises;
        vend(3'd5);
        waits = 0;
        while (req_rises - r0 < 2 && waits < 80) begin
            tick();
            waits++;
        end
        chk_num("r5_second_req_seen", req_rises - r0, 2);
        chk_bit("r5_dime_req", dime_req, 1'b1);
        chk_num("r5_dimes_before", dimes - d0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_bit("r5_async_dime_low", dime_req, 1'b0);
        chk_bit("r5_async_nickel_low", nickel_req, 1'b0);
        chk_bit("r5_async_busy_low", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        r0 = req_rises;
        run(40, dc);
        chk_num("r5_no_done", dc, 0);
        chk_num("r5_no_req", req_rises - r0, 0);
        chk_num("r5_dimes_after", dimes - d0, 1);
        chk_num("r5_nickels_after", nickels - n0, 0);
        chk_bit("r5_busy_after", busy, 1'b0);

        chk_num("never_both_reqs", both_high, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
